// File: rtl/gate_checker_if.sv
// Bus between gate_checker and its controller / gate under test.
// Parameters N_IN (gate inputs) and CNT_W (error counter width) must match
// the gate_checker instance that uses the slave modport.
//
// Handshake: i_start is a request sampled only while the checker is idle
// (o_busy low). The edge that accepts it raises o_busy; the run ends with a
// single-cycle o_done pulse, after which o_busy falls. Results (o_pass,
// o_err_cnt, o_first_fail, o_fail_valid) stay stable until the next accept.
interface gate_checker_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  localparam int P = 1 << N_IN;

  logic             i_start;
  logic [P-1:0]     i_expected;
  logic             i_dut_out;
  logic [N_IN-1:0]  o_stim;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [CNT_W-1:0] o_err_cnt;
  logic [N_IN-1:0]  o_first_fail;
  logic             o_fail_valid;
  logic [1:0]       o_dbg_state;

  modport slave (
    input  i_start, i_expected, i_dut_out,
    output o_stim, o_busy, o_done, o_pass, o_err_cnt, o_first_fail,
           o_fail_valid, o_dbg_state
  );

  modport master (
    output i_start, i_expected, i_dut_out,
    input  o_stim, o_busy, o_done, o_pass, o_err_cnt, o_first_fail,
           o_fail_valid, o_dbg_state
  );
endinterface

// File: rtl/gate_checker.sv
// gate_checker: truth-table exerciser for a small combinational gate.
// Walks all 2**N_IN input patterns in ascending order, holds each for
// SETTLE+1 cycles, samples the gate output on the last cycle and compares it
// with a truth table latched at start.
// Optional macro GATE_CHECK_STOP_ON_FAIL_EN: end the run at the first
// mismatch instead of running every pattern.
module gate_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  gate_checker_if.slave  bus
);
  localparam int P  = 1 << N_IN;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [P-1:0]     r_exp;
  logic [N_IN-1:0]  r_stim;
  logic [SW-1:0]    r_settle;
  logic [CNT_W-1:0] r_err_cnt;
  logic [N_IN-1:0]  r_first_fail;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail_valid;

  wire              w_sample   = (r_settle == SW'(SETTLE));
  wire              w_mismatch = (bus.i_dut_out != r_exp[r_stim]);
  wire              w_last     = (r_stim == N_IN'(P - 1));
  wire [CNT_W-1:0]  w_err_inc  = (&r_err_cnt) ? r_err_cnt : r_err_cnt + CNT_W'(1);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  wire              w_finish   = w_last | w_mismatch;
`else
  wire              w_finish   = w_last;
`endif

  // Run sequencer: start accept, per-pattern settle/sample, result capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_exp        <= '0;
      r_stim       <= '0;
      r_settle     <= '0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_exp        <= bus.i_expected;
            r_stim       <= '0;
            r_settle     <= '0;
            r_err_cnt    <= '0;
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          if (!w_sample) begin
            r_settle <= r_settle + SW'(1);
          end else begin
            if (w_mismatch) begin
              r_err_cnt <= w_err_inc;
              if (!r_fail_valid) begin
                r_first_fail <= r_stim;
                r_fail_valid <= 1'b1;
              end
            end
            if (w_finish) begin
              // Pass is decided on the fail flag so a saturated count still fails.
              r_pass  <= !(r_fail_valid || w_mismatch);
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_stim   <= r_stim + N_IN'(1);
              r_settle <= '0;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_stim  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_stim       = r_stim;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_pass       = r_pass;
  assign bus.o_err_cnt    = r_err_cnt;
  assign bus.o_first_fail = r_first_fail;
  assign bus.o_fail_valid = r_fail_valid;
  assign bus.o_dbg_state  = r_state;
endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three instances (2-input/settle 2, 3-input/settle 0,
// 2-input/settle 1 with a 1-bit counter), a run-time model derived from the
// pattern timing rules, a per-cycle compare and directed literal checks.
module tb_gate_checker;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic st [3];
  logic [15:0] ex [3];
  logic gsel0;    // instance 0 gate: 0 = and_gate, 1 = or_gate
  logic chk_en;
  int   checks;
  int   errors;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  gate_checker_if #(.N_IN(2), .CNT_W(8)) if0 ();
  gate_checker_if #(.N_IN(3), .CNT_W(8)) if1 ();
  gate_checker_if #(.N_IN(2), .CNT_W(1)) if2 ();

  assign if0.i_start    = st[0];
  assign if1.i_start    = st[1];
  assign if2.i_start    = st[2];
  assign if0.i_expected = ex[0][3:0];
  assign if1.i_expected = ex[1][7:0];
  assign if2.i_expected = ex[2][3:0];
  assign if0.i_dut_out  = gsel0 ? (|if0.o_stim) : (&if0.o_stim);
  assign if1.i_dut_out  = &if1.o_stim;
  assign if2.i_dut_out  = |if2.o_stim;

  gate_checker #(.N_IN(2), .SETTLE(2), .CNT_W(8)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
  gate_checker #(.N_IN(3), .SETTLE(0), .CNT_W(8)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));
  gate_checker #(.N_IN(2), .SETTLE(1), .CNT_W(1)) u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2.slave));

  logic [3:0] d_stim [3];
  logic [3:0] d_ff   [3];
  logic [7:0] d_err  [3];
  logic       d_busy [3];
  logic       d_done [3];
  logic       d_pass [3];
  logic       d_fv   [3];

  assign d_stim[0] = {2'b0, if0.o_stim};
  assign d_stim[1] = {1'b0, if1.o_stim};
  assign d_stim[2] = {2'b0, if2.o_stim};
  assign d_ff[0]   = {2'b0, if0.o_first_fail};
  assign d_ff[1]   = {1'b0, if1.o_first_fail};
  assign d_ff[2]   = {2'b0, if2.o_first_fail};
  assign d_err[0]  = if0.o_err_cnt;
  assign d_err[1]  = if1.o_err_cnt;
  assign d_err[2]  = {7'b0, if2.o_err_cnt};
  assign d_busy[0] = if0.o_busy;
  assign d_busy[1] = if1.o_busy;
  assign d_busy[2] = if2.o_busy;
  assign d_done[0] = if0.o_done;
  assign d_done[1] = if1.o_done;
  assign d_done[2] = if2.o_done;
  assign d_pass[0] = if0.o_pass;
  assign d_pass[1] = if1.o_pass;
  assign d_pass[2] = if2.o_pass;
  assign d_fv[0]   = if0.o_fail_valid;
  assign d_fv[1]   = if1.o_fail_valid;
  assign d_fv[2]   = if2.o_fail_valid;

  // ---------------- model ----------------
  // A run is described by t = edges since the accepting edge; all outputs
  // follow from t, the latched table and the gate's logic function.
  int          m_t       [3];
  bit          m_started [3];
  int          m_gate    [3];   // 0 and2, 1 or2, 2 and3
  logic [15:0] m_exp     [3];

  function automatic int n_of(input int i);
    return (i == 1) ? 3 : 2;
  endfunction
  function automatic int s_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 1);
  endfunction
  function automatic int cw_of(input int i);
    return (i == 2) ? 1 : 8;
  endfunction
  function automatic bit gate_fn(input int g, input int k);
    case (g)
      0: return (k == 3);
      1: return (k != 0);
      default: return (k == 7);
    endcase
  endfunction
  function automatic bit mism(input int i, input int k);
    return gate_fn(m_gate[i], k) != m_exp[i][k];
  endfunction
  function automatic int last_pat(input int i);
    int p;
    p = 1 << n_of(i);
    if (STOP) begin
      for (int k = 0; k < p; k++) if (mism(i, k)) return k;
    end
    return p - 1;
  endfunction
  function automatic int end_t(input int i);
    return (last_pat(i) + 1) * (s_of(i) + 1);
  endfunction

  task automatic model_out(input int i, output logic [3:0] stim, output logic busy,
                           output logic done, output logic pass, output logic [7:0] err,
                           output logic [3:0] ff, output logic fv);
    int s, l, tt, t, errs, maxc;
    stim = '0; busy = 0; done = 0; pass = 0; err = '0; ff = '0; fv = 0;
    if (m_started[i]) begin
      s  = s_of(i) + 1;
      l  = last_pat(i);
      tt = end_t(i);
      t  = m_t[i];
      busy = (t <= tt);
      done = (t == tt);
      if (t <= tt) stim = 4'((t / s > l) ? l : t / s);
      errs = 0;
      for (int k = 0; k <= l; k++) begin
        if ((k + 1) * s <= t && mism(i, k)) begin
          if (!fv) ff = 4'(k);
          fv = 1;
          errs++;
        end
      end
      maxc = (1 << cw_of(i)) - 1;
      err  = 8'((errs > maxc) ? maxc : errs);
      pass = (t >= tt) && (errs == 0);
    end
  endtask

  // Model advance: reset, start accept when idle, otherwise count edges.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_started[i] = 0;
        m_t[i]       = 0;
      end else if (!m_started[i] || m_t[i] > end_t(i)) begin
        if (st[i]) begin
          m_started[i] = 1;
          m_t[i]       = 0;
          m_exp[i]     = ex[i];
          m_gate[i]    = (i == 0) ? (gsel0 ? 1 : 0) : ((i == 1) ? 2 : 1);
        end
      end else begin
        m_t[i] = m_t[i] + 1;
      end
    end
  end

  // Per-cycle compare of every output of every instance against the model.
  always @(negedge clk) begin
    logic [3:0] e_stim, e_ff;
    logic [7:0] e_err;
    logic e_busy, e_done, e_pass, e_fv;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        model_out(i, e_stim, e_busy, e_done, e_pass, e_err, e_ff, e_fv);
        checks++;
        if ({d_stim[i], d_busy[i], d_done[i], d_pass[i], d_err[i], d_ff[i], d_fv[i]} !==
            {e_stim, e_busy, e_done, e_pass, e_err, e_ff, e_fv}) begin
          errors++;
          $display("FAIL cycle_cmp u%0d @%0t got stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b exp stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b",
                   i, $time, d_stim[i], d_busy[i], d_done[i], d_pass[i], d_err[i], d_ff[i], d_fv[i],
                   e_stim, e_busy, e_done, e_pass, e_err, e_ff, e_fv);
        end
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  // Pulse start on instance i, optionally pulse it again at busy cycle
  // pulse_at, and return the number of busy cycles and done pulses seen.
  task automatic run(input int i, input logic [15:0] e, input int pulse_at,
                     output int busy_n, output int done_n);
    bit finished;
    ex[i] = e;
    @(negedge clk);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    ex[i] = ~e;   // table must have been latched already
    busy_n = 0;
    done_n = 0;
    finished = 0;
    for (int c = 0; c < 200; c++) begin
      if (d_busy[i]) busy_n++;
      if (d_done[i]) done_n++;
      st[i] = (c == pulse_at);
      if (!d_busy[i]) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    st[i] = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL run_timeout u%0d busy still %b after 200 cycles", i, d_busy[i]);
    end
  endtask

  int bn, dn;
  bit saw_done;
  bit hit;

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 0;
    rst_n  = 1'b0;
    gsel0  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      ex[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    check("reset_busy", d_busy[0], 0);
    check("reset_stim", d_stim[0], 0);
    check("reset_pass", d_pass[0], 0);
    rst_n = 1'b1;

    // and_gate against its own table
    run(0, 16'b1000, -1, bn, dn);
    check("and_ok_busy_cycles", bn, 13);
    check("and_ok_done_pulses", dn, 1);
    check("and_ok_err", d_err[0], 0);
    check("and_ok_pass", d_pass[0], 1);
    check("and_ok_fv", d_fv[0], 0);

    // and_gate against the OR table: patterns 1 and 2 differ
    run(0, 16'b1110, -1, bn, dn);
    check("and_vs_or_busy_cycles", bn, STOP ? 7 : 13);
    check("and_vs_or_err", d_err[0], STOP ? 1 : 2);
    check("and_vs_or_ff", d_ff[0], 1);
    check("and_vs_or_fv", d_fv[0], 1);
    check("and_vs_or_pass", d_pass[0], 0);

    // or_gate against the OR table on the same instance
    gsel0 = 1'b1;
    run(0, 16'b1110, -1, bn, dn);
    check("or_ok_pass", d_pass[0], 1);
    gsel0 = 1'b0;

    // and3_gate, zero settle
    run(1, 16'h0080, -1, bn, dn);
    check("and3_busy_cycles", bn, 9);
    check("and3_pass", d_pass[1], 1);

    // reset mid-run while pattern 2 is driven
    ex[0] = 16'b1000;
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    hit = 0;
    saw_done = 0;
    for (int c = 0; c < 50; c++) begin
      if (d_done[0]) saw_done = 1;
      if (d_stim[0] == 2) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reached_stim2", hit, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy", d_busy[0], 0);
    check("rst_mid_stim", d_stim[0], 0);
    check("rst_mid_err", d_err[0], 0);
    check("rst_mid_done", d_done[0] | saw_done, 0);
    run(0, 16'b1000, -1, bn, dn);
    check("after_rst_busy_cycles", bn, 13);
    check("after_rst_pass", d_pass[0], 1);

    // or_gate against the inverted table, 1-bit counter, extra start mid-run
    run(2, 16'b0001, 1, bn, dn);
    check("sat_busy_cycles", bn, STOP ? 3 : 9);
    check("sat_done_pulses", dn, 1);
    check("sat_err", d_err[2], 1);
    check("sat_pass", d_pass[2], 0);
    check("sat_fv", d_fv[2], 1);
    check("sat_ff", d_ff[2], 0);

    // start held high: back-to-back runs with one idle cycle between
    ex[1] = 16'h0080;
    @(negedge clk);
    st[1] = 1'b1;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_done[1]) dn++;
    end
    st[1] = 1'b0;
    check("held_start_done_pulses", dn, 2);
    repeat (3) @(negedge clk);
    check("held_start_idle", d_busy[1], 0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
